// File: rtl/bus_pkg.sv
// Shared constants and state encoding for the PicoRV32 native-bus arbiter.
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [DATA_W-1:0] DEFAULT_ERR_RDATA = 32'hBADC_0DE5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pointer plus wrap-around priority search starting just after
// the most recently served master.
module rr_arbiter #(
    parameter int NUM_MASTERS = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   advance,
    input  logic [NUM_MASTERS-1:0] done_grant,
    output logic [NUM_MASTERS-1:0] next_grant,
    output logic                   any_req
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] done_idx;
    logic             found;

    // Reset points at the top master so master 0 wins the first arbitration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= IDX_W'(NUM_MASTERS - 1);
        end else if (advance) begin
            last <= done_idx;
        end
    end

    always_comb begin
        done_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (done_grant[i]) begin
                done_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        next_grant = '0;
        found      = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            int idx;
            idx = (int'(last) + 1 + i) % NUM_MASTERS;
            if (!found && req[idx]) begin
                next_grant[idx] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the PicoRV32 native memory bus between several masters, with a
// watchdog that force-completes transactions no slave acknowledges.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int                NUM_MASTERS = 2,
    parameter int                TIMEOUT     = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA   = DEFAULT_ERR_RDATA
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS-1:0]        m_valid,
    input  logic [ADDR_W*NUM_MASTERS-1:0] m_addr,
    input  logic [DATA_W*NUM_MASTERS-1:0] m_wdata,
    input  logic [STRB_W*NUM_MASTERS-1:0] m_wstrb,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          s_valid,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [STRB_W-1:0]             s_wstrb,
    input  logic                          s_ready,
    input  logic [DATA_W-1:0]             s_rdata,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic                          timeout_irq,
    output logic [ADDR_W-1:0]             err_addr
);

    bus_state_e               state, state_nxt;
    logic [NUM_MASTERS-1:0]   next_grant;
    logic                     any_req;
    logic                     done;
    logic                     timed_out;
    logic [15:0]              count;
    logic [ADDR_W-1:0]        sel_addr;
    logic [DATA_W-1:0]        sel_wdata;
    logic [STRB_W-1:0]        sel_wstrb;

    rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr_arbiter (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (m_valid),
        .advance    (done),
        .done_grant (grant),
        .next_grant (next_grant),
        .any_req    (any_req)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A slave acknowledge in the final watchdog cycle counts as a normal completion.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (s_ready) begin
                    done = 1'b1;
                end else if (count == 16'(TIMEOUT - 1)) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_valid     = (state == BUSY);
    assign m_ready     = done ? grant : '0;
    assign m_rdata     = done ? (timed_out ? ERR_RDATA : s_rdata) : '0;
    assign timeout_irq = timed_out;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (next_grant[i]) begin
                sel_addr  = sel_addr  | m_addr[ADDR_W*i +: ADDR_W];
                sel_wdata = sel_wdata | m_wdata[DATA_W*i +: DATA_W];
                sel_wstrb = sel_wstrb | m_wstrb[STRB_W*i +: STRB_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant    <= '0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_wstrb  <= '0;
            count    <= '0;
            err_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant   <= next_grant;
                        s_addr  <= sel_addr;
                        s_wdata <= sel_wdata;
                        s_wstrb <= sel_wstrb;
                        count   <= '0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        grant <= '0;
                    end else begin
                        count <= count + 16'd1;
                    end
                    if (timed_out) begin
                        err_addr <= s_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
